// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-controller bundle: hazard/cache indications in, pipeline-register controls out.
// Cache handshake: ihit/dhit are single-cycle completion strobes; a data access is pending while
// dmemREN|dmemWEN is high without dhit, and the request stays asserted until its dhit cycle.
interface pipeline_hazard_ctrl_if #(
    parameter int CNT_W = 32
) ();
    logic             ihit;
    logic             dhit;
    logic             dmemREN;
    logic             dmemWEN;
    logic             idex_mem_read;
    logic [4:0]       idex_rt;
    logic [4:0]       ifid_rs;
    logic [4:0]       ifid_rt;
    logic             ifid_uses_rt;
    logic             redirect;
    logic             exmem_halt;

    logic             pc_en;
    logic             ifid_en;
    logic             ifid_flush;
    logic             idex_en;
    logic             idex_flush;
    logic             idex_freeze;
    logic             exmem_en;
    logic             exmem_flush;
    logic             memwb_en;
    logic             halted;
    logic [CNT_W-1:0] stall_cycles;
    logic [1:0]       dbg_state;

    modport slave (
        input  ihit, dhit, dmemREN, dmemWEN, idex_mem_read, idex_rt, ifid_rs, ifid_rt,
               ifid_uses_rt, redirect, exmem_halt,
        output pc_en, ifid_en, ifid_flush, idex_en, idex_flush, idex_freeze, exmem_en,
               exmem_flush, memwb_en, halted, stall_cycles, dbg_state
    );

    modport master (
        output ihit, dhit, dmemREN, dmemWEN, idex_mem_read, idex_rt, ifid_rs, ifid_rt,
               ifid_uses_rt, redirect, exmem_halt,
        input  pc_en, ifid_en, ifid_flush, idex_en, idex_flush, idex_freeze, exmem_en,
               exmem_flush, memwb_en, halted, stall_cycles, dbg_state
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use, cache waits, redirects, halt drain,
// plus a saturating count of hazard stall cycles. FSM state is visible on bus.dbg_state.
module pipeline_hazard_ctrl #(
    parameter int CNT_W     = 32,
    parameter int DRAIN_CYC = 2
) (
    input  logic                   CLK,
    input  logic                   nRST,
    pipeline_hazard_ctrl_if.slave  bus
);
    localparam int DW = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;

    typedef enum logic [1:0] {RUN, DWAIT, DRAIN, HALTED} state_e;

    state_e           state_q, state_d;
    logic [DW-1:0]    drain_q, drain_d;
    logic [CNT_W-1:0] stall_q, stall_d;

    logic dpend, luse, stall_evt;
    logic pc_en, ifid_en, ifid_flush, idex_en, idex_flush, idex_freeze;
    logic exmem_en, exmem_flush, memwb_en, halted;

    assign dpend = (bus.dmemREN | bus.dmemWEN) & ~bus.dhit;
    assign luse  = bus.idex_mem_read & (bus.idex_rt != 5'd0) &
                   ((bus.idex_rt == bus.ifid_rs) | (bus.ifid_uses_rt & (bus.idex_rt == bus.ifid_rt)));

    always_comb begin
        state_d     = state_q;
        drain_d     = drain_q;
        stall_evt   = 1'b0;
        pc_en       = 1'b0;
        ifid_en     = 1'b0;
        ifid_flush  = 1'b0;
        idex_en     = 1'b0;
        idex_flush  = 1'b0;
        idex_freeze = 1'b0;
        exmem_en    = 1'b0;
        exmem_flush = 1'b0;
        memwb_en    = 1'b0;
        halted      = 1'b0;
        case (state_q)
            RUN: begin
                if (dpend) begin
                    idex_freeze = 1'b1;
                    stall_evt   = 1'b1;
                    state_d     = DWAIT;
                end else if (bus.exmem_halt) begin
                    ifid_flush  = 1'b1;
                    idex_flush  = 1'b1;
                    exmem_flush = 1'b1;
                    memwb_en    = 1'b1;
                    drain_d     = DW'(DRAIN_CYC - 1);
                    state_d     = DRAIN;
                end else if (bus.redirect & bus.ihit) begin
                    // The load-use victim is on the wrong path, so the redirect flush wins.
                    pc_en      = 1'b1;
                    ifid_flush = 1'b1;
                    idex_flush = 1'b1;
                    exmem_en   = 1'b1;
                    memwb_en   = 1'b1;
                    stall_evt  = 1'b1;
                end else if (luse) begin
                    idex_flush = 1'b1;
                    exmem_en   = 1'b1;
                    memwb_en   = 1'b1;
                    stall_evt  = 1'b1;
                end else if (~bus.ihit) begin
                    ifid_flush = 1'b1;
                    idex_en    = 1'b1;
                    exmem_en   = 1'b1;
                    memwb_en   = 1'b1;
                    stall_evt  = 1'b1;
                end else begin
                    pc_en    = 1'b1;
                    ifid_en  = 1'b1;
                    idex_en  = 1'b1;
                    exmem_en = 1'b1;
                    memwb_en = 1'b1;
                end
            end
            DWAIT: begin
                if (dpend) begin
                    idex_freeze = 1'b1;
                    stall_evt   = 1'b1;
                end else begin
                    pc_en    = 1'b1;
                    ifid_en  = 1'b1;
                    idex_en  = 1'b1;
                    exmem_en = 1'b1;
                    memwb_en = 1'b1;
                    state_d  = RUN;
                end
            end
            DRAIN: begin
                ifid_flush  = 1'b1;
                idex_flush  = 1'b1;
                exmem_flush = 1'b1;
                memwb_en    = 1'b1;
                if (drain_q == '0) state_d = HALTED;
                else               drain_d = drain_q - DW'(1);
            end
            HALTED: halted = 1'b1;
            default: state_d = RUN;
        endcase
        if (!nRST) begin
            stall_evt   = 1'b0;
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            ifid_flush  = 1'b1;
            idex_en     = 1'b0;
            idex_flush  = 1'b1;
            idex_freeze = 1'b0;
            exmem_en    = 1'b0;
            exmem_flush = 1'b1;
            memwb_en    = 1'b0;
            halted      = 1'b0;
        end
    end

    assign stall_d = (stall_evt && !(&stall_q)) ? stall_q + CNT_W'(1) : stall_q;

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state_q <= RUN;
            drain_q <= '0;
            stall_q <= '0;
        end else begin
            state_q <= state_d;
            drain_q <= drain_d;
            stall_q <= stall_d;
        end
    end

    assign bus.pc_en        = pc_en;
    assign bus.ifid_en      = ifid_en;
    assign bus.ifid_flush   = ifid_flush;
    assign bus.idex_en      = idex_en;
    assign bus.idex_flush   = idex_flush;
    assign bus.idex_freeze  = idex_freeze;
    assign bus.exmem_en     = exmem_en;
    assign bus.exmem_flush  = exmem_flush;
    assign bus.memwb_en     = memwb_en;
    assign bus.halted       = halted;
    assign bus.stall_cycles = stall_q;
    assign bus.dbg_state    = state_q;
endmodule
